// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Define ID_EX_PERF_EN to add the saturating bubble_count performance counter.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        valid_id,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic [4:0]  rd_id,
  input  logic        uses_rt_id,
  input  logic [31:0] rdata1_id,
  input  logic [31:0] rdata2_id,
  input  logic [31:0] imm_id,
  input  logic [31:0] pc_id,
  input  logic        regwrite_id,
  input  logic        memread_id,
  input  logic        memwrite_id,
  input  logic        memtoreg_id,
  input  logic        regdst_id,
  input  logic        alusrc_id,
  input  logic [3:0]  aluop_id,
  output logic        valid_ex,
  output logic [4:0]  rs_ex,
  output logic [4:0]  rt_ex,
  output logic [4:0]  dest_ex,
  output logic [31:0] rdata1_ex,
  output logic [31:0] rdata2_ex,
  output logic [31:0] imm_ex,
  output logic [31:0] pc_ex,
  output logic        regwrite_ex,
  output logic        memread_ex,
  output logic        memwrite_ex,
  output logic        memtoreg_ex,
  output logic        alusrc_ex,
  output logic [3:0]  aluop_ex,
  output logic        load_use_stall
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0] bubble_count
`endif
);

  logic        valid_r;
  logic [4:0]  rs_r;
  logic [4:0]  rt_r;
  logic [4:0]  dest_r;
  logic [31:0] rdata1_r;
  logic [31:0] rdata2_r;
  logic [31:0] imm_r;
  logic [31:0] pc_r;
  logic        regwrite_r;
  logic        memread_r;
  logic        memwrite_r;
  logic        memtoreg_r;
  logic        alusrc_r;
  logic [3:0]  aluop_r;

  logic        load_use_s;
  logic        bubble_s;
  logic        hold_s;
  logic [4:0]  dest_s;

  // A load into $0 never hazards; rt only matters when the ID instruction reads it.
  assign load_use_s = valid_r & memread_r & (dest_r != 5'd0) & valid_id &
                      ((dest_r == rs_id) | (uses_rt_id & (dest_r == rt_id)));
  assign dest_s     = regdst_id ? rd_id : rt_id;

  // Resolve this cycle's update: flush beats the downstream hold, which beats load-use.
  always_comb begin
    bubble_s = 1'b0;
    hold_s   = 1'b0;
    if (flush) begin
      bubble_s = 1'b1;
    end else if (stall_in) begin
      hold_s = 1'b1;
    end else if (load_use_s) begin
      bubble_s = 1'b1;
    end else begin
      bubble_s = 1'b0;
      hold_s   = 1'b0;
    end
  end

  // EX register bank: clear on reset or bubble, freeze on hold, otherwise capture ID.
  always_ff @(posedge clk) begin
    if (rst || bubble_s) begin
      valid_r    <= 1'b0;
      rs_r       <= 5'd0;
      rt_r       <= 5'd0;
      dest_r     <= 5'd0;
      rdata1_r   <= 32'd0;
      rdata2_r   <= 32'd0;
      imm_r      <= 32'd0;
      pc_r       <= 32'd0;
      regwrite_r <= 1'b0;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;
      alusrc_r   <= 1'b0;
      aluop_r    <= 4'd0;
    end else if (!hold_s) begin
      valid_r    <= valid_id;
      rs_r       <= rs_id;
      rt_r       <= rt_id;
      dest_r     <= dest_s;
      rdata1_r   <= rdata1_id;
      rdata2_r   <= rdata2_id;
      imm_r      <= imm_id;
      pc_r       <= pc_id;
      regwrite_r <= regwrite_id & valid_id;
      memread_r  <= memread_id  & valid_id;
      memwrite_r <= memwrite_id & valid_id;
      memtoreg_r <= memtoreg_id & valid_id;
      alusrc_r   <= alusrc_id   & valid_id;
      aluop_r    <= aluop_id;
    end
  end

  assign valid_ex       = valid_r;
  assign rs_ex          = rs_r;
  assign rt_ex          = rt_r;
  assign dest_ex        = dest_r;
  assign rdata1_ex      = rdata1_r;
  assign rdata2_ex      = rdata2_r;
  assign imm_ex         = imm_r;
  assign pc_ex          = pc_r;
  assign regwrite_ex    = regwrite_r;
  assign memread_ex     = memread_r;
  assign memwrite_ex    = memwrite_r;
  assign memtoreg_ex    = memtoreg_r;
  assign alusrc_ex      = alusrc_r;
  assign aluop_ex       = aluop_r;
  assign load_use_stall = load_use_s;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_count_r;

  // Saturating count of inserted bubbles; a simultaneous flush and hazard counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count_r <= 32'd0;
    end else if (bubble_s && (bubble_count_r != 32'hFFFF_FFFF)) begin
      bubble_count_r <= bubble_count_r + 32'd1;
    end
  end

  assign bubble_count = bubble_count_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: per-cycle reference model plus directed literal checks.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_in, flush, valid_id, uses_rt_id;
  logic [4:0]  rs_id, rt_id, rd_id;
  logic [31:0] rdata1_id, rdata2_id, imm_id, pc_id;
  logic        regwrite_id, memread_id, memwrite_id, memtoreg_id, regdst_id, alusrc_id;
  logic [3:0]  aluop_id;

  logic        valid_ex, regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, alusrc_ex;
  logic [4:0]  rs_ex, rt_ex, dest_ex;
  logic [31:0] rdata1_ex, rdata2_ex, imm_ex, pc_ex;
  logic [3:0]  aluop_ex;
  logic        load_use_stall;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_count;
`endif

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .valid_id(valid_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .uses_rt_id(uses_rt_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id), .pc_id(pc_id),
    .regwrite_id(regwrite_id), .memread_id(memread_id), .memwrite_id(memwrite_id),
    .memtoreg_id(memtoreg_id), .regdst_id(regdst_id), .alusrc_id(alusrc_id),
    .aluop_id(aluop_id),
    .valid_ex(valid_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .dest_ex(dest_ex),
    .rdata1_ex(rdata1_ex), .rdata2_ex(rdata2_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
    .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
    .memtoreg_ex(memtoreg_ex), .alusrc_ex(alusrc_ex), .aluop_ex(aluop_ex),
    .load_use_stall(load_use_stall)
`ifdef ID_EX_PERF_EN
    , .bubble_count(bubble_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the EX stage must hold, as one record.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, dest;
    logic [31:0] r1, r2, imm, pc;
    logic        rw, mr, mw, mt, as;
    logic [3:0]  aluop;
  } ex_t;

  ex_t         mdl;
  logic [31:0] mdl_bc;
  bit          mdl_ok = 1'b0;

  function automatic logic hazard_f(input ex_t e);
    if (!(e.valid && e.mr && e.dest != 5'd0 && valid_id)) return 1'b0;
    return (e.dest == rs_id) || (uses_rt_id && e.dest == rt_id);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl    <= '0;
      mdl_bc <= 32'd0;
      mdl_ok <= 1'b1;
    end else if (flush || (!stall_in && hazard_f(mdl))) begin
      mdl <= '0;
      if (mdl_bc != 32'hFFFF_FFFF) mdl_bc <= mdl_bc + 32'd1;
    end else if (!stall_in) begin
      mdl <= '{valid: valid_id, rs: rs_id, rt: rt_id,
               dest: (regdst_id ? rd_id : rt_id),
               r1: rdata1_id, r2: rdata2_id, imm: imm_id, pc: pc_id,
               rw: regwrite_id && valid_id, mr: memread_id && valid_id,
               mw: memwrite_id && valid_id, mt: memtoreg_id && valid_id,
               as: alusrc_id && valid_id, aluop: aluop_id};
    end
  end

  // Compare every output against the model each cycle, away from the active edge.
  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("valid_ex", 32'(valid_ex), 32'(mdl.valid));
      chk("rs_ex", 32'(rs_ex), 32'(mdl.rs));
      chk("rt_ex", 32'(rt_ex), 32'(mdl.rt));
      chk("dest_ex", 32'(dest_ex), 32'(mdl.dest));
      chk("rdata1_ex", rdata1_ex, mdl.r1);
      chk("rdata2_ex", rdata2_ex, mdl.r2);
      chk("imm_ex", imm_ex, mdl.imm);
      chk("pc_ex", pc_ex, mdl.pc);
      chk("regwrite_ex", 32'(regwrite_ex), 32'(mdl.rw));
      chk("memread_ex", 32'(memread_ex), 32'(mdl.mr));
      chk("memwrite_ex", 32'(memwrite_ex), 32'(mdl.mw));
      chk("memtoreg_ex", 32'(memtoreg_ex), 32'(mdl.mt));
      chk("alusrc_ex", 32'(alusrc_ex), 32'(mdl.as));
      chk("aluop_ex", 32'(aluop_ex), 32'(mdl.aluop));
      if (!flush) chk("load_use_stall", 32'(load_use_stall), 32'(hazard_f(mdl)));
`ifdef ID_EX_PERF_EN
      chk("bubble_count", bubble_count, mdl_bc);
`endif
    end
  end

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urt, input logic rdst,
                        input logic mr, input logic rw, input logic [31:0] d1);
    valid_id    = v;
    rs_id       = rs;
    rt_id       = rt;
    rd_id       = rd;
    uses_rt_id  = urt;
    regdst_id   = rdst;
    memread_id  = mr;
    regwrite_id = rw;
    memtoreg_id = mr;
    alusrc_id   = mr;
    memwrite_id = d1[8];
    rdata1_id   = d1;
    rdata2_id   = d1 ^ 32'hA5A5_0000;
    imm_id      = d1 + 32'd4;
    pc_id       = 32'h0040_0000 + d1;
    aluop_id    = d1[3:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lw into register r (rt form, regdst=0)
  task automatic load_into(input logic [4:0] r, input logic [31:0] d1);
    set_id(1'b1, 5'd1, r, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, d1);
    tick();
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    tick();
    tick();
    chk("rst valid_ex", 32'(valid_ex), 32'd0);
    chk("rst dest_ex", 32'(dest_ex), 32'd0);
    chk("rst rdata1_ex", rdata1_ex, 32'd0);
    chk("rst regwrite_ex", 32'(regwrite_ex), 32'd0);
    chk("rst load_use_stall", 32'(load_use_stall), 32'd0);
    rst = 1'b0;

    // normal capture, regdst=1 then regdst=0
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11);
    tick();
    chk("cap rs_ex", 32'(rs_ex), 32'd3);
    chk("cap rt_ex", 32'(rt_ex), 32'd4);
    chk("cap dest_ex rd", 32'(dest_ex), 32'd5);
    chk("cap rdata1_ex", rdata1_ex, 32'h11);
    chk("cap regwrite_ex", 32'(regwrite_ex), 32'd1);
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h12);
    tick();
    chk("cap dest_ex rt", 32'(dest_ex), 32'd4);

    // load-use on rs: one bubble, then the held add is captured
    load_into(5'd8, 32'h100);
    set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    #1 chk("lu rs stall", 32'(load_use_stall), 32'd1);
    tick();
    chk("lu bubble valid_ex", 32'(valid_ex), 32'd0);
    chk("lu bubble regwrite_ex", 32'(regwrite_ex), 32'd0);
    chk("lu stall released", 32'(load_use_stall), 32'd0);
    tick();
    chk("lu add rs_ex", 32'(rs_ex), 32'd8);
    chk("lu add dest_ex", 32'(dest_ex), 32'd10);
    chk("lu add valid_ex", 32'(valid_ex), 32'd1);

    // load-use on rt: only when rt is read
    load_into(5'd8, 32'h101);
    set_id(1'b1, 5'd2, 5'd8, 5'd11, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
    #1 chk("lu rt unused", 32'(load_use_stall), 32'd0);
    tick();
    chk("lu rt unused captured", 32'(dest_ex), 32'd11);
    load_into(5'd8, 32'h102);
    set_id(1'b1, 5'd2, 5'd8, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 32'h301);
    #1 chk("lu rt used", 32'(load_use_stall), 32'd1);
    tick();
    chk("lu rt bubble", 32'(valid_ex), 32'd0);
    tick();
    chk("lu rt captured", 32'(valid_ex), 32'd1);

    // load into $0 never stalls
    load_into(5'd0, 32'h400);
    set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 32'h401);
    #1 chk("lu r0", 32'(load_use_stall), 32'd0);
    tick();
    chk("lu r0 captured", 32'(dest_ex), 32'd12);

    // invalid ID slot: control bits forced to 0
    set_id(1'b0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500);
    tick();
    chk("inv valid_ex", 32'(valid_ex), 32'd0);
    chk("inv regwrite_ex", 32'(regwrite_ex), 32'd0);
    chk("inv memread_ex", 32'(memread_ex), 32'd0);

    // flush beats stall_in and a pending hazard
    load_into(5'd8, 32'h103);
    begin
      logic [31:0] bc_pre;
      bc_pre = mdl_bc;
      set_id(1'b1, 5'd8, 5'd8, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 32'h201);
      stall_in = 1'b1;
      flush    = 1'b1;
      tick();
      chk("flush valid_ex", 32'(valid_ex), 32'd0);
      chk("flush dest_ex", 32'(dest_ex), 32'd0);
      chk("flush memread_ex", 32'(memread_ex), 32'd0);
`ifdef ID_EX_PERF_EN
      chk("flush bubble_count", bubble_count, bc_pre + 32'd1);
`else
      chk("flush model count", mdl_bc, bc_pre + 32'd1);
`endif
    end
    flush    = 1'b0;
    stall_in = 1'b0;

    // hold 3 cycles with a hazard pending; stall still asserted upstream
    load_into(5'd8, 32'h600);
    stall_in = 1'b1;
    set_id(1'b1, 5'd8, 5'd9, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 32'h601);
    #1 chk("hold stall asserted", 32'(load_use_stall), 32'd1);
    tick();
    chk("hold1 memread_ex", 32'(memread_ex), 32'd1);
    chk("hold1 rdata1_ex", rdata1_ex, 32'h600);
    tick();
    tick();
    chk("hold3 rdata1_ex", rdata1_ex, 32'h600);
    chk("hold3 dest_ex", 32'(dest_ex), 32'd8);
    stall_in = 1'b0;
    tick();
    chk("post-hold bubble", 32'(valid_ex), 32'd0);
    tick();
    chk("post-hold capture", rdata1_ex, 32'h601);

    // reset in the middle of a stall
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h700);
    tick();
    stall_in = 1'b1;
    rst      = 1'b1;
    tick();
    chk("rst mid-stall valid_ex", 32'(valid_ex), 32'd0);
    chk("rst mid-stall rdata1_ex", rdata1_ex, 32'd0);
    rst      = 1'b0;
    stall_in = 1'b0;

`ifdef ID_EX_PERF_EN
    // counter saturation
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    force dut.bubble_count_r = 32'hFFFF_FFFE;
    mdl_bc = 32'hFFFF_FFFE;
    tick();
    release dut.bubble_count_r;
    flush = 1'b1;
    tick();
    tick();
    tick();
    chk("saturate bubble_count", bubble_count, 32'hFFFF_FFFF);
    flush = 1'b0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
